// File: rtl/mul_seq_if.sv
// mul_seq request/response bundle.
// The decode/hazard side drives the master end.
interface mul_seq_if;
  logic        start;
  logic        op_mla;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c;
  logic        flush;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] result;
  logic [1:0]  flags;

  modport master (
    output start, op_mla, a, b, c, flush,
    input  busy, done, stall, result, flags
  );

  modport slave (
    input  start, op_mla, a, b, c, flush,
    output busy, done, stall, result, flags
  );
endinterface

// File: rtl/mul_seq.sv
// Iterative shift-add MUL/MLA sequencer for execute.
// Holds the pipeline via stall until the result is ready.
module mul_seq #(
  parameter int STEP_BITS  = 1,
  parameter bit EARLY_TERM = 1
) (
  input logic      clk,
  input logic      reset,
  mul_seq_if.slave bus
);
  localparam int STEPS = 32 / STEP_BITS;

  typedef enum logic [1:0] {
    IDLE, MUL, ACC, DONE
  } state_t;

  state_t      state, nstate;
  logic [31:0] ma, mb, acc, cr;
  logic [31:0] part, acc_mul, mb_nx, fin;
  logic [31:0] res_q;
  logic [1:0]  flg_q;
  logic [5:0]  cnt;
  logic        mla_q, last, accept, load;

  always_comb begin
    part = '0;
    for (int i = 0; i < STEP_BITS; i++)
      if (mb[i]) part = part + (ma << i);
  end

  assign acc_mul = acc + part;
  assign mb_nx   = mb >> STEP_BITS;
  assign last    = EARLY_TERM ? (mb_nx == '0)
                              : (cnt == 6'(STEPS - 1));
  assign accept  = (state == IDLE) & bus.start & ~bus.flush;
  assign fin     = (state == ACC) ? acc + cr : acc_mul;
  // DONE is only ever entered from MUL or ACC
  assign load    = (nstate == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (accept) nstate = MUL;
      MUL: begin
        if (bus.flush) nstate = IDLE;
        else if (last) nstate = mla_q ? ACC : DONE;
      end
      ACC:  nstate = bus.flush ? IDLE : DONE;
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state != IDLE);
    bus.done  = (state == DONE);
    bus.stall = accept | (state == MUL)
              | (state == ACC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ma    <= '0;
      mb    <= '0;
      acc   <= '0;
      cr    <= '0;
      cnt   <= '0;
      mla_q <= 1'b0;
      res_q <= '0;
      flg_q <= 2'b00;
    end else begin
      case (state)
        IDLE: if (accept) begin
          ma    <= bus.a;
          mb    <= bus.b;
          acc   <= '0;
          cr    <= bus.c;
          cnt   <= '0;
          mla_q <= bus.op_mla;
        end
        MUL: begin
          acc <= acc_mul;
          ma  <= ma << STEP_BITS;
          mb  <= mb_nx;
          cnt <= cnt + 6'd1;
        end
        ACC: acc <= acc + cr;
        default: ;
      endcase
      if (load) begin
        res_q <= fin;
        flg_q <= {fin[31], fin == '0};
      end
    end
  end

  assign bus.result = res_q;
  assign bus.flags  = flg_q;
endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq across three configurations.
// d0: STEP_BITS=1 early-term, d1: 1 full, d2: 4 full.
module tb_mul_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        start, op_mla, flush;
  logic [31:0] a, b, c;

  mul_seq_if i0 ();
  mul_seq_if i1 ();
  mul_seq_if i2 ();

  assign i0.start = start;  assign i0.op_mla = op_mla;
  assign i0.a = a;  assign i0.b = b;  assign i0.c = c;
  assign i0.flush = flush;
  assign i1.start = start;  assign i1.op_mla = op_mla;
  assign i1.a = a;  assign i1.b = b;  assign i1.c = c;
  assign i1.flush = flush;
  assign i2.start = start;  assign i2.op_mla = op_mla;
  assign i2.a = a;  assign i2.b = b;  assign i2.c = c;
  assign i2.flush = flush;

  mul_seq #(.STEP_BITS(1), .EARLY_TERM(1)) d0 (
    .clk(clk), .reset(reset), .bus(i0.slave));
  mul_seq #(.STEP_BITS(1), .EARLY_TERM(0)) d1 (
    .clk(clk), .reset(reset), .bus(i1.slave));
  mul_seq #(.STEP_BITS(4), .EARLY_TERM(0)) d2 (
    .clk(clk), .reset(reset), .bus(i2.slave));

  always #5 clk = ~clk;

  logic [2:0]  dn;
  logic [31:0] ro [3];
  logic [1:0]  fo [3];
  assign dn = {i2.done, i1.done, i0.done};
  assign ro[0] = i0.result;
  assign ro[1] = i1.result;
  assign ro[2] = i2.result;
  assign fo[0] = i0.flags;
  assign fo[1] = i1.flags;
  assign fo[2] = i2.flags;

  int checks = 0;
  int errors = 0;

  int          dcyc [3];
  int          dcnt [3];
  logic [31:0] dres [3];
  logic [1:0]  dflg [3];
  logic [40:0] st0, bz0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic run(input logic [31:0] ta, tb, tc,
                     input logic mla, flush0,
                     input int pulse, fl, rs);
    for (int j = 0; j < 3; j++) begin
      dcyc[j] = 0;  dcnt[j] = 0;
      dres[j] = 'x; dflg[j] = 'x;
    end
    st0 = '0;  bz0 = '0;
    @(negedge clk);
    a = ta;  b = tb;  c = tc;  op_mla = mla;
    start = 1'b1;  flush = flush0;
    #1;
    st0[0] = i0.stall;
    bz0[0] = i0.busy;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      st0[k] = i0.stall;
      bz0[k] = i0.busy;
      for (int j = 0; j < 3; j++) begin
        if (dn[j]) begin
          if (dcnt[j] == 0) begin
            dcyc[j] = k;
            dres[j] = ro[j];
            dflg[j] = fo[j];
          end
          dcnt[j]++;
        end
      end
      start = (k == pulse);
      flush = (k == fl);
      reset = (k == rs);
    end
  endtask

  initial begin
    reset = 1'b1;  start = 1'b0;  flush = 1'b0;
    op_mla = 1'b0;  a = '0;  b = '0;  c = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", i0.result, 32'h0);
    chk("rst_flags", {30'h0, i0.flags}, 32'h0);
    chk("rst_ctl", {29'h0, i0.busy, i0.done, i0.stall}, 32'h0);
    reset = 1'b0;

    run(32'd6, 32'd7, 32'd0, 1'b0, 1'b0, 0, 0, 0);
    chk("mul67_cyc", dcyc[0], 4);
    chk("mul67_res", dres[0], 32'd42);
    chk("mul67_flg", {30'h0, dflg[0]}, 32'h0);
    chk("mul67_stall", {27'h0, st0[4:0]}, 32'b01111);
    chk("mul67_busy", {27'h0, bz0[5:0]}, 32'b011110);
    chk("mul67_d1cyc", dcyc[1], 33);
    chk("mul67_d1res", dres[1], 32'd42);
    chk("mul67_d2cyc", dcyc[2], 9);
    chk("mul67_d2res", dres[2], 32'd42);

    run(32'hFFFFFFFF, 32'd2, 32'd5, 1'b1, 1'b0, 0, 0, 0);
    chk("mla_cyc", dcyc[0], 4);
    chk("mla_res", dres[0], 32'h3);
    chk("mla_flg", {30'h0, dflg[0]}, 32'h0);
    chk("mla_d1cyc", dcyc[1], 34);
    chk("mla_d2cyc", dcyc[2], 10);
    chk("mla_d2res", dres[2], 32'h3);

    run(32'h80000000, 32'd1, 32'd0, 1'b0, 1'b0, 0, 0, 0);
    chk("neg_cyc", dcyc[0], 2);
    chk("neg_res", dres[0], 32'h80000000);
    chk("neg_flg", {30'h0, dflg[0]}, 32'h2);

    run(32'h1234, 32'd0, 32'd0, 1'b0, 1'b0, 0, 0, 0);
    chk("zero_cyc", dcyc[0], 2);
    chk("zero_res", dres[0], 32'h0);
    chk("zero_flg", {30'h0, dflg[0]}, 32'h1);
    chk("zero_d1res", dres[1], 32'h0);

    run(32'h12345, 32'd1, 32'd0, 1'b0, 1'b0, 0, 0, 0);
    chk("full1_cyc", dcyc[1], 33);
    chk("full1_res", dres[1], 32'h12345);
    chk("full4_cyc", dcyc[2], 9);
    chk("full4_res", dres[2], 32'h12345);

    run(32'd5, 32'd9, 32'd0, 1'b0, 1'b0, 2, 0, 0);
    chk("ign_cyc", dcyc[0], 5);
    chk("ign_cnt", dcnt[0], 1);
    chk("ign_res", dres[0], 32'd45);
    chk("ign_d2cnt", dcnt[2], 1);

    run(32'd3, 32'hFFFF, 32'd0, 1'b0, 1'b0, 0, 5, 0);
    chk("fl_cnt", dcnt[0], 0);
    chk("fl_busy6", {31'h0, bz0[6]}, 32'h0);
    chk("fl_busy5", {31'h0, bz0[5]}, 32'h1);
    chk("fl_res", i0.result, 32'd45);
    chk("fl_d1cnt", dcnt[1], 0);
    chk("fl_d1res", i1.result, 32'd45);

    run(32'd2, 32'd3, 32'd1, 1'b1, 1'b0, 0, 0, 3);
    chk("rs_cnt", dcnt[0], 0);
    chk("rs_busy3", {31'h0, bz0[3]}, 32'h1);
    chk("rs_busy4", {31'h0, bz0[4]}, 32'h0);
    chk("rs_stall4", {31'h0, st0[4]}, 32'h0);
    chk("rs_res", i0.result, 32'h0);
    chk("rs_flg", {30'h0, i0.flags}, 32'h0);
    chk("rs_d2res", i2.result, 32'h0);

    run(32'd7, 32'd7, 32'd0, 1'b0, 1'b1, 0, 0, 0);
    chk("sf_stall0", {31'h0, st0[0]}, 32'h0);
    chk("sf_busy", {30'h0, bz0[2:1]}, 32'h0);
    chk("sf_cnt", dcnt[0] + dcnt[1] + dcnt[2], 0);
    chk("sf_res", i0.result, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
